// File: rtl/sync_dd_pkg.sv
// Shared constants and elaboration helpers for the sync_dd multi-bit synchronizer.
// Build option SYNC_DD_EDGE_DET_EN is consumed by sync_dd_bit and sync_dd.
package sync_dd_pkg;

    localparam int SYNC_DD_MIN_STAGES = 2;
    localparam int SYNC_DD_MAX_STAGES = 4;
    localparam int SYNC_DD_DEF_STAGES = 2;

    // Evaluated on parameters only, so it folds to a constant at elaboration.
    function automatic bit sync_dd_stages_legal(input int stages);
        return (stages >= SYNC_DD_MIN_STAGES) && (stages <= SYNC_DD_MAX_STAGES);
    endfunction

endpackage

// File: rtl/sync_dd_bit.sv
// One-bit flop-chain synchronizer with optional rise/fall pulse outputs.
// Define SYNC_DD_EDGE_DET_EN to add the history register and sync_rise/sync_fall ports.
module sync_dd_bit
    import sync_dd_pkg::*;
#(
    parameter int   STAGES    = SYNC_DD_DEF_STAGES,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_,
    input  logic sync_in,
    output logic sync_out
`ifdef SYNC_DD_EDGE_DET_EN
    ,
    output logic sync_rise,
    output logic sync_fall
`endif
);

    // Kept as discrete, adjacent flops: shift-register extraction or retiming would defeat metastability settling.
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO", DONT_RETIME = "TRUE", syn_srlstyle = "registers", syn_preserve = 1 *)
    logic [STAGES-1:0] r_stage;

    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            r_stage <= {STAGES{RESET_VAL}};
        end else begin
            r_stage <= {r_stage[STAGES-2:0], sync_in};
        end
    end

    assign sync_out = r_stage[STAGES-1];

`ifdef SYNC_DD_EDGE_DET_EN
    logic r_hist;

    // History resets to the same value as the chain so release never fakes an edge.
    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            r_hist <= RESET_VAL;
        end else begin
            r_hist <= sync_out;
        end
    end

    assign sync_rise = sync_out & ~r_hist;
    assign sync_fall = r_hist & ~sync_out;
`endif

endmodule

// File: rtl/sync_dd.sv
// WIDTH independent single-bit synchronizers into the clk domain; no cross-bit coherency.
// Define SYNC_DD_EDGE_DET_EN to expose per-bit sync_rise/sync_fall pulses.
module sync_dd
    import sync_dd_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = SYNC_DD_DEF_STAGES,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] sync_out
`ifdef SYNC_DD_EDGE_DET_EN
    ,
    output logic [WIDTH-1:0] sync_rise,
    output logic [WIDTH-1:0] sync_fall
`endif
);

    if (!sync_dd_stages_legal(STAGES)) begin : g_bad_stages
        $error("sync_dd: STAGES=%0d outside legal range %0d..%0d",
               STAGES, SYNC_DD_MIN_STAGES, SYNC_DD_MAX_STAGES);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sync_dd_bit #(
            .STAGES    (STAGES),
            .RESET_VAL (RESET_VAL[i])
        ) u_bit (
            .clk       (clk),
            .reset_    (reset_),
            .sync_in   (sync_in[i]),
            .sync_out  (sync_out[i])
`ifdef SYNC_DD_EDGE_DET_EN
            ,
            .sync_rise (sync_rise[i]),
            .sync_fall (sync_fall[i])
`endif
        );
    end

endmodule

// File: tb/tb_sync_dd.sv
// Directed scoreboard bench for sync_dd: three configurations share one clock and reset.
// Edge-pulse checks are compiled in only when SYNC_DD_EDGE_DET_EN is defined.
module tb_sync_dd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_ = 1'b1;
    logic       a_in;
    logic       b_in;
    logic [7:0] c_in;
    wire        a_out;
    wire        b_out;
    wire  [7:0] c_out;
`ifdef SYNC_DD_EDGE_DET_EN
    wire        a_rise, a_fall, b_rise, b_fall;
    wire  [7:0] c_rise, c_fall;
`endif

    // a: WIDTH=1 STAGES=2 RESET_VAL=0
    sync_dd #(.WIDTH(1), .STAGES(2), .RESET_VAL(1'b0)) u_a (
        .clk(clk), .reset_(reset_), .sync_in(a_in), .sync_out(a_out)
`ifdef SYNC_DD_EDGE_DET_EN
        , .sync_rise(a_rise), .sync_fall(a_fall)
`endif
    );

    // b: WIDTH=1 STAGES=3 RESET_VAL=1
    sync_dd #(.WIDTH(1), .STAGES(3), .RESET_VAL(1'b1)) u_b (
        .clk(clk), .reset_(reset_), .sync_in(b_in), .sync_out(b_out)
`ifdef SYNC_DD_EDGE_DET_EN
        , .sync_rise(b_rise), .sync_fall(b_fall)
`endif
    );

    // c: WIDTH=8 STAGES=4 RESET_VAL=0
    sync_dd #(.WIDTH(8), .STAGES(4), .RESET_VAL(8'h00)) u_c (
        .clk(clk), .reset_(reset_), .sync_in(c_in), .sync_out(c_out)
`ifdef SYNC_DD_EDGE_DET_EN
        , .sync_rise(c_rise), .sync_fall(c_fall)
`endif
    );

    typedef struct {
        int         due;
        logic [7:0] out;
        logic [7:0] rise;
        logic [7:0] fall;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int cyc      = 0;
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int dut, input int due, input logic [7:0] o,
                        input logic [7:0] r, input logic [7:0] f);
        exp_t e;
        e.due  = due;
        e.out  = o;
        e.rise = r;
        e.fall = f;
        case (dut)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic check_due();
        exp_t e;
        while (q_a.size() > 0 && q_a[0].due <= cyc) begin
            e = q_a.pop_front();
            chk($sformatf("a_out@%0d", e.due), 8'(a_out), e.out);
`ifdef SYNC_DD_EDGE_DET_EN
            chk($sformatf("a_rise@%0d", e.due), 8'(a_rise), e.rise);
            chk($sformatf("a_fall@%0d", e.due), 8'(a_fall), e.fall);
`endif
        end
        while (q_b.size() > 0 && q_b[0].due <= cyc) begin
            e = q_b.pop_front();
            chk($sformatf("b_out@%0d", e.due), 8'(b_out), e.out);
`ifdef SYNC_DD_EDGE_DET_EN
            chk($sformatf("b_rise@%0d", e.due), 8'(b_rise), e.rise);
            chk($sformatf("b_fall@%0d", e.due), 8'(b_fall), e.fall);
`endif
        end
        while (q_c.size() > 0 && q_c[0].due <= cyc) begin
            e = q_c.pop_front();
            chk($sformatf("c_out@%0d", e.due), c_out, e.out);
`ifdef SYNC_DD_EDGE_DET_EN
            chk($sformatf("c_rise@%0d", e.due), c_rise, e.rise);
            chk($sformatf("c_fall@%0d", e.due), c_fall, e.fall);
`endif
        end
    endtask

    // cyc counts rising edges; results are sampled on the following falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_due();
    endtask

    task automatic chk_reset_state(input string when);
        chk({when, "_a_out"}, 8'(a_out), 8'h00);
        chk({when, "_b_out"}, 8'(b_out), 8'h01);
        chk({when, "_c_out"}, c_out, 8'h00);
`ifdef SYNC_DD_EDGE_DET_EN
        chk({when, "_a_pulses"}, {6'd0, a_rise, a_fall}, 8'h00);
        chk({when, "_b_pulses"}, {6'd0, b_rise, b_fall}, 8'h00);
        chk({when, "_c_rise"}, c_rise, 8'h00);
        chk({when, "_c_fall"}, c_fall, 8'h00);
`endif
    endtask

    initial begin
        logic [7:0] prev;
        logic [7:0] v;

        a_in = 1'b0;
        b_in = 1'b1;
        c_in = 8'h00;
        repeat (3) tick();
        chk_reset_state("reset");

        // Release; b holds 1 through release and must stay quiet.
        reset_ = 1'b0;
        for (int d = 4; d <= 9; d++)  push(0, d, 8'h00, 8'h00, 8'h00);
        for (int d = 4; d <= 18; d++) push(1, d, 8'h01, 8'h00, 8'h00);
        for (int d = 4; d <= 14; d++) push(2, d, 8'h00, 8'h00, 8'h00);

        // a: 0->1 sampled at edge 10, visible after edge 11.
        while (cyc < 9) tick();
        a_in = 1'b1;
        push(0, 10, 8'h00, 8'h00, 8'h00);
        push(0, 11, 8'h01, 8'h01, 8'h00);
        push(0, 12, 8'h01, 8'h00, 8'h00);

        // c: 0xA5 sampled at edge 13, visible after edge 16.
        while (cyc < 12) tick();
        c_in = 8'hA5;
        push(2, 15, 8'h00, 8'h00, 8'h00);
        push(2, 16, 8'hA5, 8'hA5, 8'h00);
        push(2, 17, 8'hA5, 8'h00, 8'h00);

        // b: 1->0 sampled at edge 20, visible after edge 22.
        while (cyc < 19) tick();
        b_in = 1'b0;
        push(1, 21, 8'h01, 8'h00, 8'h00);
        push(1, 22, 8'h00, 8'h00, 8'h01);
        push(1, 23, 8'h00, 8'h00, 8'h00);

        // c: input toggles every cycle; every edge must surface as its own pulse.
        while (cyc < 21) tick();
        prev = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            v    = (i % 2 == 1) ? 8'hFF : 8'h00;
            c_in = v;
            push(2, cyc + 4, v, v & ~prev, prev & ~v);
            prev = v;
            tick();
        end
        push(2, 29, 8'hFF, 8'h00, 8'h00);

        // a: 1->0 fall.
        while (cyc < 26) tick();
        a_in = 1'b0;
        push(0, 27, 8'h01, 8'h00, 8'h00);
        push(0, 28, 8'h00, 8'h00, 8'h01);
        push(0, 29, 8'h00, 8'h00, 8'h00);

        // Launch new values, then reset while they are in flight.
        while (cyc < 30) tick();
        a_in = 1'b1;
        c_in = 8'h3C;
        tick();
        reset_ = 1'b1;
        #1;
        chk_reset_state("midrst");
        c_in = 8'h00;
        tick();
        chk_reset_state("midrst_hold");
        reset_ = 1'b0;

        push(0, 33, 8'h00, 8'h00, 8'h00);
        push(0, 34, 8'h01, 8'h01, 8'h00);
        push(0, 35, 8'h01, 8'h00, 8'h00);
        push(1, 33, 8'h01, 8'h00, 8'h00);
        push(1, 34, 8'h01, 8'h00, 8'h00);
        push(1, 35, 8'h00, 8'h00, 8'h01);
        push(1, 36, 8'h00, 8'h00, 8'h00);
        for (int d = 33; d <= 37; d++) push(2, d, 8'h00, 8'h00, 8'h00);

        while (cyc < 38) tick();
        chk("scoreboard_drained", 8'(q_a.size() + q_b.size() + q_c.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_dd.md
SYNC_DD -- requirements
Module: sync_dd

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter WIDTH, default 1: number of independent single-bit signals synchronized.
REQ-003 Parameter STAGES, default 2: flip-flop stages per bit; legal range 2..4.
REQ-004 Parameter RESET_VAL, default 0 (WIDTH bits): value loaded into every stage on reset.
REQ-005 clk  input  1  destination-domain clock; all state updates on its rising edge.
REQ-006 reset_  input  1  asynchronous reset, active-high, despite the trailing-underscore name.
REQ-007 sync_in  input  WIDTH  asynchronous input, any domain or off-chip pin.
REQ-008 sync_out  output  WIDTH  synchronized copy of sync_in, driven directly from the final stage flop.
REQ-009 sync_rise  output  WIDTH  one-cycle pulse per bit on a 0->1 transition of sync_out; present only with SYNC_DD_EDGE_DET_EN.
REQ-010 sync_fall  output  WIDTH  one-cycle pulse per bit on a 1->0 transition of sync_out; present only with SYNC_DD_EDGE_DET_EN.

Function
REQ-011 Each bit SHALL pass through a chain of STAGES flip-flops: stage 0 samples sync_in, and each later stage samples the previous stage.
REQ-012 A stable change on sync_in sampled at rising edge k SHALL appear on sync_out immediately after edge k+STAGES-1.
- For STAGES=2, the change appears after edge k+1.
REQ-013 sync_out SHALL be a register output, with no combinational path from sync_in.
REQ-014 Bits SHALL be synchronized independently; there is no coherency guarantee across bits of a multi-bit bus.
REQ-015 An input pulse shorter than one clk period MAY be lost; a pulse held for at least two clk periods SHALL appear on sync_out.
REQ-016 With edge detection, a history register SHALL hold the previous sync_out value.
- sync_rise = sync_out AND NOT history.
- sync_fall = history AND NOT sync_out.
- Each pulse is asserted exactly in the cycle sync_out first shows the new value.
REQ-017 sync_rise and sync_fall SHALL never be high together for the same bit.
REQ-018 An input toggling every cycle SHALL produce alternating rise/fall pulses once it reaches sync_out; edges are not merged.

Reset
REQ-019 While reset_=1, all stage flops and the history register SHALL be forced asynchronously to RESET_VAL.
- Resulting outputs: sync_out=RESET_VAL, sync_rise=0, sync_fall=0.
REQ-020 The first cycle after deassertion SHALL NOT produce an edge pulse.
- An edge is reported only if a later sample differs from RESET_VAL.
REQ-021 Reset asserted mid-propagation SHALL discard in-flight values.
REQ-022 After reset is released, propagation SHALL restart from sync_in.
- sync_out reflects sync_in no later than STAGES edges after deassertion.

Configuration
REQ-023 Macro SYNC_DD_EDGE_DET_EN SHALL select edge detection.
- Defined: the sync_rise and sync_fall ports and the history register exist.
- Undefined: those ports and the register are absent, and sync_out behaviour is identical.

Structure
REQ-024 A shared package sync_dd_pkg SHALL hold:
- SYNC_DD_MIN_STAGES=2, SYNC_DD_MAX_STAGES=4, SYNC_DD_DEF_STAGES=2;
- an elaboration-time legality check for STAGES.
REQ-025 A sub-module sync_dd_bit SHALL implement the one-bit flop chain plus optional edge logic; sync_dd SHALL instantiate it WIDTH times in a generate loop.
REQ-026 Stage flops SHALL carry synthesis attributes that mark them as synchronizer registers: no retiming, no SRL inference, placed adjacent.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- WIDTH=1, STAGES=2, reset released, sync_in 0->1 at edge 10 -> sync_out=1 after edge 11; sync_rise=1 for that one cycle only.
- RESET_VAL=1, sync_in held 1 through reset release -> sync_out stays 1; no sync_rise and no sync_fall pulse.
- STAGES=3, sync_in 1->0 at edge 20 -> sync_out=0 after edge 22; sync_fall=1 for exactly one cycle.
- sync_in=1 propagating, reset_ pulsed high for 1 cycle at the edge after sampling -> sync_out=RESET_VAL immediately, then 1 again within STAGES edges of release.
- WIDTH=8, sync_in=0xA5 applied at one edge -> sync_out=0xA5 after STAGES-1 further edges; sync_rise=0xA5 for one cycle.
- SYNC_DD_EDGE_DET_EN undefined -> elaboration succeeds without the sync_rise/sync_fall ports, and the sync_out timing matches the scenarios above.
